// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Shares the single register-file write port between three result producers
// (ALU = src 0, FPU = src 1, memory unit = src 2). Every source owns a small
// FIFO; a round-robin arbiter drains at most one head entry per cycle into a
// registered write-back port. An integrated scoreboard keeps one pending bit
// per architectural register so issue logic can detect RAW/WAW hazards, and
// per-source busy flags let issue throttle producers before their FIFO fills.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   alu_addr/alu_val           ALU result (addr != 0 means valid)
//   fpu_addr/fpu_val           FPU result (addr != 0 means valid)
//   mem_addr/mem_val           load result (addr != 0 means valid)
//   iss_dd                     destination of the instruction issued now
//   q_rs/q_rt/q_dd             hazard query addresses
//   haz_rs/haz_rt/haz_dd       pending bit of each query (combinational)
//   src_busy[2:0]              FIFO count >= DEPTH-1 (ALU, FPU, MEM)
//   wb_addr/wb_val             registered write-back port (addr 0 = no write)
//   ovf[2:0]                   sticky per-source FIFO overflow
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_val,
    input  logic [ADDR_W-1:0] fpu_addr,
    input  logic [DATA_W-1:0] fpu_val,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [ADDR_W-1:0] iss_dd,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    input  logic [ADDR_W-1:0] q_dd,
    output logic              haz_rs,
    output logic              haz_rt,
    output logic              haz_dd,
    output logic [2:0]        src_busy,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_val,
    output logic [2:0]        ovf
);

    localparam int NSRC  = 3;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NREG  = 1 << ADDR_W;

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] BUSY_LVL = (PTR_W+1)'(DEPTH - 1);

    logic [ADDR_W-1:0] in_addr [NSRC];
    logic [DATA_W-1:0] in_val  [NSRC];

    logic [ADDR_W-1:0] fifo_addr [NSRC][DEPTH];
    logic [DATA_W-1:0] fifo_val  [NSRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr    [NSRC];
    logic [PTR_W-1:0]  rd_ptr    [NSRC];
    logic [PTR_W:0]    count     [NSRC];

    logic [1:0]        rr_ptr;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;

    logic [NSRC-1:0]   req;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   accept;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [2:0]        cand;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_val;

    assign in_addr[0] = alu_addr;
    assign in_addr[1] = fpu_addr;
    assign in_addr[2] = mem_addr;
    assign in_val[0]  = alu_val;
    assign in_val[1]  = fpu_val;
    assign in_val[2]  = mem_val;

    // A push is accepted unless the FIFO is full and is not being drained
    // this same cycle; a full FIFO that is popped can take the new entry.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            req[i]      = (count[i] != '0);
            push[i]     = (in_addr[i] != '0);
            pop[i]      = grant_valid && (grant_idx == 2'(i));
            accept[i]   = push[i] && ((count[i] != FULL_LVL) || pop[i]);
            src_busy[i] = (count[i] >= BUSY_LVL);
        end
    end

    // Round-robin search starting at rr_ptr and wrapping 0->1->2->0; the
    // first non-empty FIFO found wins, so there is never more than one grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 3'd0;
        for (int k = 0; k < NSRC; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_valid && req[cand[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    always_comb begin
        head_addr = '0;
        head_val  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (pop[i]) begin
                head_addr = fifo_addr[i][rd_ptr[i]];
                head_val  = fifo_val[i][rd_ptr[i]];
            end
        end
    end

    // The issue-side set is applied after the write-back clear so that a new
    // producer for the same register keeps the pending bit alive.
    always_comb begin
        pending_nxt = pending;
        if (grant_valid) begin
            pending_nxt[head_addr] = 1'b0;
        end
        if (iss_dd != '0) begin
            pending_nxt[iss_dd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // FIFO storage needs no reset: only count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
                fifo_addr[i][wr_ptr[i]] <= in_addr[i];
                fifo_val[i][wr_ptr[i]]  <= in_val[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr  <= 2'd0;
            pending <= '0;
            wb_addr <= '0;
            wb_val  <= '0;
            ovf     <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (accept[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (accept[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!accept[i] && pop[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
                if (push[i] && !accept[i]) begin
                    ovf[i] <= 1'b1;
                end
            end
            pending <= pending_nxt;
            if (grant_valid) begin
                wb_addr <= head_addr;
                wb_val  <= head_val;
                rr_ptr  <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end else begin
                wb_addr <= '0;
            end
        end
    end

    assign haz_rs = pending[q_rs];
    assign haz_rt = pending[q_rt];
    assign haz_dd = pending[q_dd];

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between three result producers: ALU (src 0), FPU (src 1) and memory unit (src 2).
- Each source has its own small FIFO. A round-robin arbiter drains one entry per cycle into a registered write-back port.
- An integrated scoreboard tracks in-flight destinations. Issue logic queries it for RAW and WAW hazards and uses per-source busy flags to throttle issue.

Parameters:
DEPTH, 2, entries per source FIFO (power of two, >=2)
ADDR_W, 6, register address width; address 0 means "no write"
DATA_W, 32, result width

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
alu_addr  in  ADDR_W  ALU result destination; nonzero = valid this cycle
alu_val  in  DATA_W  ALU result value
fpu_addr  in  ADDR_W  FPU result destination; nonzero = valid
fpu_val  in  DATA_W  FPU result value
mem_addr  in  ADDR_W  load result destination; nonzero = valid
mem_val  in  DATA_W  load result value
iss_dd  in  ADDR_W  destination of instruction issued this cycle; 0 = none
q_rs  in  ADDR_W  hazard query, source operand s
q_rt  in  ADDR_W  hazard query, source operand t
q_dd  in  ADDR_W  hazard query, destination
haz_rs  out  1  pending[q_rs], combinational
haz_rt  out  1  pending[q_rt], combinational
haz_dd  out  1  pending[q_dd], combinational
src_busy  out  3  per source: FIFO count >= DEPTH-1 (bit0 ALU, bit1 FPU, bit2 MEM)
wb_addr  out  ADDR_W  register-file write address; 0 = no write
wb_val  out  DATA_W  register-file write data
ovf  out  3  sticky per-source overflow error

Behaviour:
- Reset (rstn=0 at posedge):
  - All FIFOs empty, pending vector cleared, RR pointer = 0.
  - wb_addr=0, wb_val=0, ovf=0.
  - Reset mid-operation discards all queued results with no write-back.
- Enqueue:
  - At each posedge, each source with nonzero addr pushes {addr,val} into its FIFO.
  - Enqueue and dequeue on the same FIFO in the same cycle are legal, including when the FIFO is full; count is then unchanged.
  - A push into a full FIFO with no same-cycle pop is dropped and sets the corresponding ovf bit (sticky until reset).
- Arbitration (combinational on FIFO heads; result registered):
  - Requesters are the non-empty FIFOs.
  - Search starts at the source after the last granted one (RR pointer) and wraps 0->1->2->0.
  - The grant pops that FIFO head and loads wb_addr/wb_val at the same posedge. The RR pointer becomes grant+1 mod 3.
  - No requester: wb_addr <= 0; wb_val and the RR pointer hold.
  - Exactly one grant per cycle.
- Latency:
  - Result presented in cycle N is enqueued at end of N. Earliest arbitration is cycle N+1; wb_addr is valid in cycle N+2.
  - There is no FIFO bypass.
- src_busy:
  - Registered-count based, so the issue stage has one cycle of slack for a result already in flight.
  - Issue must not target a unit whose busy bit is 1.
- Scoreboard:
  - pending is a 2^ADDR_W-bit vector; bit 0 is hardwired 0.
  - Set at posedge when iss_dd != 0.
  - Cleared at the posedge a granted entry loads wb_addr with that address.
  - Same-edge set and clear of the same register: set wins (new producer).
  - At most one producer per register may be in flight. Issue logic enforces this via haz_dd; the block does not count duplicates.
- haz_* reflect the pending register state (pre-edge). Query of address 0 returns 0.

Test Plan:
- Single ALU result: alu_addr=5, alu_val=0x1234 in cycle 1 -> wb_addr=5, wb_val=0x1234 in cycle 3; pending[5] set by iss_dd=5 in cycle 0 and clear after cycle 2 edge; haz_rs with q_rs=5 is 1 in cycles 1-2 and 0 in cycle 3.
- Three-way contention: ALU addr 1, FPU addr 2, MEM addr 3 all in cycle 1, RR pointer 0 -> wb_addr sequence 1,2,3 in cycles 3,4,5, then 0.
- Fairness: ALU valid every cycle (addrs 1..8), MEM one result addr 9 in cycle 1 -> addr 9 is written no later than the 2nd grant after it is enqueued; no FIFO overflow.
- Back-pressure: FPU pushes 2 entries while ALU+MEM keep winning -> src_busy[1]=1 once count>=1. Third push while full with no pop -> dropped, ovf[1]=1, remaining two entries still written back correctly.
- Set/clear collision: wb of addr 7 granted in same cycle as iss_dd=7 -> pending[7]=1 afterward; haz_dd for q_dd=7 is 1.
- Reset mid-flight: two entries queued in each FIFO, rstn=0 for one cycle -> wb_addr=0, src_busy=0, ovf=0, all haz_* = 0. No queued result is ever written back.
